// File: rtl/toggle_cover_collector.sv
// Toggle coverage collector: detects per-bit rise/fall events, marks each cover
// point hit once, and streams every point's global index exactly once per reset epoch.
module toggle_cover_collector #(
  parameter int WIDTH       = 8,
  parameter int COVER_BASE  = 0,
  parameter int COVER_TOTAL = 8744,
  parameter int FIFO_DEPTH  = 4,
  parameter int IDX_W       = 32
) (
  input  logic                             gbl_clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic [WIDTH-1:0]                 sig,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [IDX_W-1:0]                 out_index,
  output logic [$clog2(2*WIDTH+1)-1:0]     covered_cnt,
  output logic                             all_covered
);

  localparam int NPTS   = 2 * WIDTH;
  localparam int CNT_W  = $clog2(NPTS + 1);
  localparam int PT_W   = $clog2(NPTS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [IDX_W-1:0]  BASE_IDX  = IDX_W'(COVER_BASE);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NPTS);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("toggle_cover_collector: WIDTH must be in 1..64");
    end
    if (COVER_BASE + 2 * WIDTH > COVER_TOTAL) begin : g_bad_space
      $error("toggle_cover_collector: cover points exceed COVER_TOTAL");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("toggle_cover_collector: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [WIDTH-1:0]  r_prev;
  logic              r_prev_valid;
  logic [NPTS-1:0]   r_hit;
  logic [NPTS-1:0]   r_pending;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_all;
  logic [IDX_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FCNT_W-1:0] r_fcnt;

  logic              w_sample;
  logic [NPTS-1:0]   w_det;
  logic [NPTS-1:0]   w_new;
  logic [CNT_W-1:0]  w_new_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [NPTS-1:0]   w_grant;
  logic [PT_W-1:0]   w_grant_pt;
  logic              w_push;
  logic              w_pop;

  assign w_sample = en & r_prev_valid;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_det
      assign w_det[2*gi]   = w_sample & ~r_prev[gi] &  sig[gi];
      assign w_det[2*gi+1] = w_sample &  r_prev[gi] & ~sig[gi];
    end
  endgenerate

  assign w_new = w_det & ~r_hit;

  always_comb begin
    w_new_cnt = '0;
    for (int i = 0; i < NPTS; i++) begin
      w_new_cnt = w_new_cnt + CNT_W'(w_new[i]);
    end
  end

  assign w_cnt_next = r_cnt + w_new_cnt;

  // Isolate the lowest pending bit, then encode it to a point number.
  assign w_grant = r_pending & (~r_pending + NPTS'(1));

  always_comb begin
    w_grant_pt = '0;
    for (int i = 0; i < NPTS; i++) begin
      if (w_grant[i]) begin
        w_grant_pt = w_grant_pt | PT_W'(i);
      end
    end
  end

  // Fullness uses the registered count only, so a same-cycle pop never frees a slot.
  assign out_valid = (r_fcnt != '0);
  assign w_push    = (|r_pending) && (r_fcnt != FIFO_FULL);
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_hit        <= '0;
      r_pending    <= '0;
      r_cnt        <= '0;
      r_all        <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fcnt       <= '0;
    end else begin
      if (en) begin
        r_prev       <= sig;
        r_prev_valid <= 1'b1;
      end
      r_hit     <= r_hit | w_new;
      r_pending <= (r_pending & ~(w_push ? w_grant : '0)) | w_new;
      r_cnt     <= w_cnt_next;
      r_all     <= (w_cnt_next == FULL_CNT);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + FCNT_W'(1);
        2'b01:   r_fcnt <= r_fcnt - FCNT_W'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  always_ff @(posedge gbl_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= BASE_IDX + IDX_W'(w_grant_pt);
    end
  end

  // Forced to zero when empty so stale entries never show after reset or drain.
  assign out_index   = out_valid ? r_mem[r_rd_ptr] : '0;
  assign covered_cnt = r_cnt;
  assign all_covered = r_all;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Directed bench for toggle_cover_collector: a set/queue reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_toggle_cover_collector;

  localparam int W     = 8;
  localparam int BASE  = 100;
  localparam int DEPTH = 4;
  localparam int NP    = 2 * W;

  logic          gbl_clk;
  logic          reset;
  logic          en;
  logic [W-1:0]  sig;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_index;
  logic [4:0]    covered_cnt;
  logic          all_covered;

  toggle_cover_collector #(
    .WIDTH(W), .COVER_BASE(BASE), .COVER_TOTAL(8744), .FIFO_DEPTH(DEPTH), .IDX_W(32)
  ) dut (
    .gbl_clk(gbl_clk), .reset(reset), .en(en), .sig(sig),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .covered_cnt(covered_cnt), .all_covered(all_covered)
  );

  initial gbl_clk = 1'b0;
  always #5 gbl_clk = ~gbl_clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sets of hit/pending points and a queue of queued indices.
  bit          m_hit  [NP];
  bit          m_pend [NP];
  bit [W-1:0]  m_prev;
  bit          m_pv;
  int unsigned m_q[$];

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < NP; i++) c += m_hit[i];
    return c;
  endfunction

  always @(posedge gbl_clk) begin
    if (!reset) begin
      m_q.delete();
      m_pv = 0;
      for (int i = 0; i < NP; i++) begin
        m_hit[i]  = 0;
        m_pend[i] = 0;
      end
    end else begin
      int sz;
      sz = m_q.size();
      if (sz > 0 && out_ready) void'(m_q.pop_front());
      if (sz < DEPTH) begin
        for (int p = 0; p < NP; p++) begin
          if (m_pend[p]) begin
            m_q.push_back(BASE + p);
            m_pend[p] = 0;
            break;
          end
        end
      end
      if (en) begin
        if (m_pv) begin
          for (int b = 0; b < W; b++) begin
            if (m_prev[b] != sig[b]) begin
              int p;
              p = m_prev[b] ? 2*b + 1 : 2*b;
              if (!m_hit[p]) begin
                m_hit[p]  = 1;
                m_pend[p] = 1;
              end
            end
          end
        end
        m_prev = sig;
        m_pv   = 1;
      end
    end
  end

  always @(negedge gbl_clk) begin
    if (chk_on) begin
      chk("model_valid", out_valid, m_q.size() > 0);
      if (m_q.size() > 0) chk("model_index", out_index, m_q[0]);
      chk("model_cnt", covered_cnt, m_cnt());
      chk("model_all", all_covered, m_cnt() == NP);
    end
  end

  int unsigned xfer_log[$];
  always @(negedge gbl_clk) begin
    if (chk_on && reset && out_valid && out_ready) begin
      xfer_log.push_back(out_index);
      $display("xfer index=%0d cnt=%0d t=%0t", out_index, covered_cnt, $time);
    end
  end

  task automatic tick();
    @(posedge gbl_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; en = 1'b0; sig = '0; out_ready = 1'b1;
    tick();
    chk_on = 1;
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_index", out_index, 0);
    chk("rst_cnt", covered_cnt, 0);
    chk("rst_all", all_covered, 0);

    // Constant signal produces nothing.
    reset = 1'b1; en = 1'b1;
    repeat (100) tick();
    chk("const_valid", out_valid, 0);
    chk("const_cnt", covered_cnt, 0);

    // Single rise then fall on bit 0.
    xfer_log.delete();
    sig = 8'h01; tick();
    chk("rise_cnt_t1", covered_cnt, 1);
    chk("rise_valid_t1", out_valid, 0);
    tick();
    chk("rise_valid_t2", out_valid, 1);
    chk("rise_index_t2", out_index, 100);
    sig = 8'h00; tick();
    chk("fall_cnt", covered_cnt, 2);
    tick();
    chk("fall_valid", out_valid, 1);
    chk("fall_index", out_index, 101);
    tick();

    // Repeated toggles never re-emit.
    for (int i = 0; i < 20; i++) begin
      sig[0] = ~sig[0];
      tick();
    end
    repeat (5) tick();
    chk("rep_xfers", xfer_log.size(), 2);
    if (xfer_log.size() == 2) begin
      chk("rep_first", xfer_log[0], 100);
      chk("rep_second", xfer_log[1], 101);
    end
    chk("rep_cnt", covered_cnt, 2);

    // Multi-bit burst: first sample FF detects nothing, then all bits fall.
    do_reset();
    sig = 8'hFF; tick();
    chk("burst_first_valid", out_valid, 0);
    chk("burst_first_cnt", covered_cnt, 0);
    sig = 8'h00; tick();
    chk("burst_cnt", covered_cnt, 8);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("burst_valid", out_valid, 1);
      chk("burst_index", out_index, 101 + 2*k);
      tick();
    end
    chk("burst_empty", out_valid, 0);

    // Backpressure: FIFO fills, head stays stable, then drains in order.
    out_ready = 1'b0;
    do_reset();
    sig = 8'h00; tick();
    sig = 8'hFF; tick();
    sig = 8'h00; tick();
    for (int k = 0; k < 8; k++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_index", out_index, 100);
      tick();
    end
    chk("bp_cnt", covered_cnt, 16);
    chk("bp_all", all_covered, 1);
    xfer_log.delete();
    out_ready = 1'b1;
    repeat (24) tick();
    chk("bp_xfers", xfer_log.size(), 16);
    if (xfer_log.size() == 16) begin
      for (int i = 0; i < 16; i++) chk("bp_order", xfer_log[i], 100 + i);
    end
    chk("bp_empty", out_valid, 0);

    // Reset while entries are undelivered starts a fresh epoch.
    out_ready = 1'b0;
    do_reset();
    sig = 8'h00; tick();
    sig = 8'hFF; tick();
    sig = 8'h00; tick();
    repeat (3) tick();
    reset = 1'b0; tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", covered_cnt, 0);
    chk("mid_rst_all", all_covered, 0);
    chk("mid_rst_index", out_index, 0);
    reset = 1'b1; out_ready = 1'b1;
    sig = 8'h00; tick();
    sig = 8'h01; tick();
    tick();
    chk("reepoch_valid", out_valid, 1);
    chk("reepoch_index", out_index, 100);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
